instr_prefetch_queue: RTL and testbench
=======================================

Name: instr_prefetch_queue

Overview:
Fetch front-end sitting directly upstream of the pipeline's decode stage.
- Issues one-at-a-time requests to the instruction memory over a req/ack handshake.
- Buffers returned instructions with their PCs in a small FIFO.
- Presents them to decode over a valid/ready interface.
- Supports branch/jump redirect: flushes the queue and discards any in-flight fetch.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
PC_W, 16, PC/address width
INSTR_W, 16, instruction width
RESET_PC, 16'h0000, first fetch address after reset

Ports:
clk  in  1  clock, all state updates on rising edge
Rst  in  1  synchronous reset, active-high
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  PC_W  new fetch address
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  PC_W  fetch address, stable while imem_req=1
imem_ack  in  1  imem_rdata valid this cycle; completes the request
imem_rdata  in  INSTR_W  fetched instruction
out_valid  out  1  out_instr/out_pc valid for decode
out_instr  out  INSTR_W  head instruction
out_pc  out  PC_W  PC of head instruction
out_ready  in  1  decode accepts head (pop when out_valid && out_ready)
queue_count  out  $clog2(DEPTH)+1  occupied entries (registered)

Behaviour:
- Reset: state=IDLE, fetch_pc=RESET_PC, count=0, imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0. Reset mid-request abandons the request; an ack arriving in IDLE is ignored.
- FSM states: IDLE, WAIT, DISCARD.
  - IDLE -> WAIT when credit available (count + pending < DEPTH, where pending = ack in flight); imem_req=1, imem_addr=fetch_pc registered.
  - WAIT, imem_ack=1, no redirect: push {fetch_pc, imem_rdata}; fetch_pc += 1 (mod 2^PC_W, 16'hFFFF -> 16'h0000). Go to WAIT with next address if credit remains after push/pop, else IDLE.
  - WAIT, redirect without ack -> DISCARD. imem_req stays high and imem_addr stays unchanged until ack (protocol never drops a request).
  - WAIT, redirect and ack in the same cycle: data dropped -> IDLE.
  - DISCARD, imem_ack: drop data -> IDLE.
- Redirect, any state: FIFO count=0 next cycle and fetch_pc=redirect_pc. First request to redirect_pc is asserted the cycle after redirect if the FSM is in or returns to IDLE.
- Credit: uses registered count. A pop in the same cycle does not free credit until the next cycle. The FIFO can never overflow.
- out_valid = (count != 0) && !redirect_valid. A pop during a redirect cycle never occurs.
- Push and pop in the same cycle: count unchanged; order preserved.
- Latency: ack at cycle M -> out_valid at M+1 (registered FIFO). With no stalls, steady-state throughput is one instruction per memory round trip.

Optional Feature:
PREFETCH_BYPASS_EN:
- Defined: when the FIFO is empty, no redirect, and imem_ack=1, imem_rdata/imem_addr drive out_instr/out_pc combinationally and out_valid=1 in the same cycle.
  - If out_ready=1, the entry is not written to the FIFO.
  - Otherwise it is written normally.
- Undefined: no combinational path from imem_ack/imem_rdata to out_*; one-cycle minimum latency.

Decomposition:
- Shared package pf_pkg: FSM state enum (IDLE/WAIT/DISCARD), PC_W/INSTR_W defaults, NOP encoding 16'h7000.
- Sub-module pf_fifo: synchronous FIFO of {pc, instr}, DEPTH entries, push/pop/flush, count, pointer wrap at DEPTH.
- FSM, credit logic and bypass live in the top level.

Test Plan:
- Reset release, memory acks 1 cycle after every req, out_ready=1 -> imem_addr sequence 0,1,2,...; out_pc matches out_instr each beat; queue_count never exceeds DEPTH.
- out_ready=0 for 20 cycles -> queue_count saturates at 4, imem_req drops to 0. Raise out_ready -> four entries pop in order (PCs 0..3), fetching resumes at PC 4.
- Redirect to 16'h0040 while WAIT with ack delayed 3 cycles -> FSM in DISCARD, returned data not enqueued. Next request addr=0x0040, queue_count=0 the cycle after redirect.
- Redirect and imem_ack in the same cycle -> data dropped, next imem_addr=redirect_pc, no stale out_valid.
- RESET_PC=16'hFFFE, continuous acks -> PCs FFFE, FFFF, 0000, 0001.
- Rst asserted mid-request with a later ack -> outputs at reset values; ack ignored; first request after release goes to RESET_PC.

Source files
------------

// File: rtl/pf_pkg.sv
// rtl/pf_pkg.sv - shared types and constants for the instruction prefetch queue
// Contents: fetch FSM state enum, default PC/instruction widths, NOP encoding.
package pf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } pf_state_e;

  localparam int          PF_PC_W    = 16;
  localparam int          PF_INSTR_W = 16;
  localparam logic [15:0] PF_NOP     = 16'h7000;

endpackage

// File: rtl/pf_fifo.sv
// rtl/pf_fifo.sv - synchronous FIFO of {pc, instr} entries with flush
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   flush           empties the FIFO on the next edge (wins over push/pop)
//   push, din       write one entry
//   pop, dout       dout is the head entry; pop removes it
//   count           registered occupancy, 0..DEPTH
module pf_fifo #(
  parameter int  DEPTH = 4,
  parameter int  W     = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Storage is not reset; occupancy gates every use of the head entry.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so AW-bit pointers wrap at DEPTH naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - instruction fetch front-end with prefetch FIFO and redirect
// Ports:
//   clk, Rst                      clock, synchronous active-high reset
//   redirect_valid, redirect_pc   flush queue, restart fetch at redirect_pc
//   imem_req, imem_addr           request to instruction memory (held until ack)
//   imem_ack, imem_rdata          memory response, completes the request
//   out_valid, out_instr, out_pc  head of queue towards decode
//   out_ready                     decode accepts head
//   queue_count                   registered occupancy
// Optional macro PREFETCH_BYPASS_EN: when the queue is empty an acked
// instruction is presented to decode in the same cycle.
module instr_prefetch_queue
  import pf_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter int               PC_W     = PF_PC_W,
  parameter int               INSTR_W  = PF_INSTR_W,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  localparam int              CW       = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               out_ready,
  output logic [CW-1:0]      queue_count
);

  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  pf_state_e                 r_state;
  pf_state_e                 w_state_next;
  logic [PC_W-1:0]           r_fetch_pc;
  logic [PC_W-1:0]           r_addr;
  logic [CW-1:0]             w_count;
  logic [PC_W+INSTR_W-1:0]   w_head;
  logic                      w_accept;
  logic                      w_bypass;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_fifo_valid;
  logic                      w_credit_idle;
  logic                      w_credit_after;
  logic [PC_W-1:0]           w_fetch_pc_inc;

  // An ack is only meaningful for a live request in WAIT; acks in IDLE or
  // DISCARD, or coinciding with a redirect, are dropped.
  assign w_accept = (r_state == WAIT) && imem_ack && !redirect_valid;

`ifdef PREFETCH_BYPASS_EN
  assign w_bypass = w_accept && (w_count == '0);
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed instruction that decode takes immediately never enters the FIFO.
  assign w_push       = w_accept && !(w_bypass && out_ready);
  assign w_fifo_valid = (w_count != '0) && !redirect_valid;
  assign w_pop        = w_fifo_valid && out_ready;

  // Credit is based on the registered count only, so a same-cycle pop never
  // lets a new request out; at most one request is ever outstanding.
  assign w_credit_idle  = {1'b0, w_count} < DEPTH_C;
  assign w_credit_after = ({1'b0, w_count} + {{CW{1'b0}}, w_push}) < DEPTH_C;
  assign w_fetch_pc_inc = r_fetch_pc + PC_W'(1);

  pf_fifo #(
    .DEPTH (DEPTH),
    .W     (PC_W + INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (Rst),
    .flush (redirect_valid),
    .push  (w_push),
    .din   ({r_addr, imem_rdata}),
    .pop   (w_pop),
    .dout  (w_head),
    .count (w_count)
  );

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      // A redirect empties the FIFO, so credit is guaranteed for its fetch.
      IDLE: begin
        if (redirect_valid || w_credit_idle) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            w_state_next = IDLE;
          end else if (w_credit_after) begin
            w_state_next = WAIT;
          end else begin
            w_state_next = IDLE;
          end
        end else if (redirect_valid) begin
          w_state_next = DISCARD;
        end
      end
      // The stale request stays on the bus until memory acks it.
      DISCARD: begin
        if (imem_ack) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // r_fetch_pc is the next address to fetch; r_addr is what is on the bus.
  always_ff @(posedge clk) begin
    if (Rst) begin
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
    end else begin
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
      end else if (w_accept) begin
        r_fetch_pc <= w_fetch_pc_inc;
      end

      if (r_state == IDLE) begin
        if (redirect_valid) begin
          r_addr <= redirect_pc;
        end else if (w_credit_idle) begin
          r_addr <= r_fetch_pc;
        end
      end else if (w_accept && w_credit_after) begin
        r_addr <= w_fetch_pc_inc;
      end
    end
  end

  always_comb begin
    imem_req  = (r_state != IDLE);
    imem_addr = r_addr;
    out_valid = w_fifo_valid;
    out_pc    = w_fifo_valid ? w_head[PC_W+INSTR_W-1:INSTR_W] : '0;
    out_instr = w_fifo_valid ? w_head[INSTR_W-1:0] : '0;
`ifdef PREFETCH_BYPASS_EN
    if (w_bypass) begin
      out_valid = 1'b1;
      out_pc    = r_addr;
      out_instr = imem_rdata;
    end
`endif
  end

  assign queue_count = w_count;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - directed self-checking bench for instr_prefetch_queue
module tb_instr_prefetch_queue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        Rst;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        out_ready;
  logic [2:0]  queue_count;

  logic        redirect_valid_w;
  logic [15:0] redirect_pc_w;
  logic        imem_req_w;
  logic [15:0] imem_addr_w;
  logic        imem_ack_w;
  logic [15:0] imem_rdata_w;
  logic        out_valid_w;
  logic [15:0] out_instr_w;
  logic [15:0] out_pc_w;
  logic        out_ready_w;
  logic [2:0]  queue_count_w;

  int          errors = 0;
  int          checks = 0;

  int          mem_lat  = 1;
  bit          mem_auto = 1'b1;
  int          mem_cnt  = 0;
  bit          ack_seen = 1'b0;
  logic [15:0] first_ack_addr;
  logic [15:0] last_ack_addr;

  instr_prefetch_queue #(
    .DEPTH(4), .PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)
  ) u_dut (
    .clk(clk), .Rst(Rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .queue_count(queue_count)
  );

  instr_prefetch_queue #(
    .DEPTH(4), .PC_W(16), .INSTR_W(16), .RESET_PC(16'hFFFE)
  ) u_dut_wrap (
    .clk(clk), .Rst(Rst),
    .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w),
    .out_valid(out_valid_w), .out_instr(out_instr_w), .out_pc(out_pc_w),
    .out_ready(out_ready_w), .queue_count(queue_count_w)
  );

  function automatic logic [15:0] instr_of(input logic [15:0] pc);
    return pc ^ 16'hA500;
  endfunction

  // Memory models: main DUT acks mem_lat cycles after a request appears,
  // the wrap DUT acks every cycle its request is high.
  task automatic mem_drive();
    if (mem_auto) begin
      if (imem_req) begin
        if (mem_cnt >= mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = instr_of(imem_addr);
          if (!ack_seen) first_ack_addr = imem_addr;
          ack_seen      = 1'b1;
          last_ack_addr = imem_addr;
          mem_cnt       = 0;
        end else begin
          imem_ack = 1'b0;
          mem_cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        mem_cnt  = 0;
      end
    end
    imem_ack_w   = imem_req_w;
    imem_rdata_w = instr_of(imem_addr_w);
  endtask

  task automatic cycle();
    mem_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Rst            = 1'b1;
    redirect_valid = 1'b0;
    mem_auto       = 1'b1;
    mem_lat        = 1;
    imem_ack       = 1'b0;
    out_ready      = 1'b0;
    out_ready_w    = 1'b0;
    cycle();
    cycle();
    Rst     = 1'b0;
    mem_cnt = 0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    cycle();
    cycle();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h expected 0000", imem_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_instr !== 16'h0000) begin errors++; $display("FAIL reset_out_instr: got %h expected 0000", out_instr); end
    checks++; if (out_pc !== 16'h0000) begin errors++; $display("FAIL reset_out_pc: got %h expected 0000", out_pc); end
    checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", queue_count); end
    checks++; if (imem_addr_w !== 16'hFFFE) begin errors++; $display("FAIL reset_addr_wrap: got %h expected fffe", imem_addr_w); end
  endtask

  task automatic test_stream();
    int pops = 0;
    int acks = 0;
    logic [15:0] exp_pc = 16'h0000;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 80 && pops < 8; i++) begin
      if (out_valid && out_ready) begin
        checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL stream_pc: got %h expected %h", out_pc, exp_pc); end
        checks++; if (out_instr !== instr_of(exp_pc)) begin errors++; $display("FAIL stream_instr: got %h expected %h", out_instr, instr_of(exp_pc)); end
        exp_pc++;
        pops++;
      end
      ack_seen = 1'b0;
      cycle();
      checks++; if (queue_count > 3'd4) begin errors++; $display("FAIL stream_count_bound: got %0d expected <=4", queue_count); end
      if (ack_seen) begin
        checks++; if (last_ack_addr !== 16'(acks)) begin errors++; $display("FAIL stream_addr: got %h expected %h", last_ack_addr, 16'(acks)); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_latency: out_valid got %b expected 1", out_valid); end
        acks++;
      end
    end
    checks++; if (pops < 8) begin errors++; $display("FAIL stream_timeout: got %0d pops expected 8", pops); end
  endtask

  task automatic test_backpressure();
    int waited = 0;
    do_reset();
    repeat (20) cycle();
    checks++; if (queue_count !== 3'd4) begin errors++; $display("FAIL bp_count_full: got %0d expected 4", queue_count); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_drop: got %b expected 0", imem_req); end
    ack_seen  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
      checks++; if (out_pc !== 16'(k)) begin errors++; $display("FAIL bp_pop_pc: got %h expected %h", out_pc, 16'(k)); end
      checks++; if (out_instr !== instr_of(16'(k))) begin errors++; $display("FAIL bp_pop_instr: got %h expected %h", out_instr, instr_of(16'(k))); end
      cycle();
    end
    while (!ack_seen && waited < 20) begin
      cycle();
      waited++;
    end
    checks++; if (!ack_seen) begin errors++; $display("FAIL bp_resume_timeout: got no ack expected fetch"); end
    else if (first_ack_addr !== 16'h0004) begin errors++; $display("FAIL bp_resume_addr: got %h expected 0004", first_ack_addr); end
  endtask

  task automatic test_redirect_discard();
    int waited = 0;
    do_reset();
    while (queue_count !== 3'd2 && waited < 30) begin
      cycle();
      waited++;
    end
    checks++; if (queue_count !== 3'd2) begin errors++; $display("FAIL disc_fill: got %0d expected 2", queue_count); end
    mem_lat        = 3;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL disc_valid_during: got %b expected 0", out_valid); end
    ack_seen = 1'b0;
    cycle();
    redirect_valid = 1'b0;
    checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL disc_flush: got %0d expected 0", queue_count); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL disc_req_held: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 16'h0002) begin errors++; $display("FAIL disc_addr_held: got %h expected 0002", imem_addr); end
    waited = 0;
    while (!ack_seen && waited < 10) begin
      cycle();
      waited++;
    end
    checks++; if (waited !== 3) begin errors++; $display("FAIL disc_ack_cycles: got %0d expected 3", waited); end
    checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL disc_not_enqueued: got %0d expected 0", queue_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL disc_no_valid: got %b expected 0", out_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL disc_idle: got %b expected 0", imem_req); end
    mem_lat = 1;
    cycle();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL disc_new_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 16'h0040) begin errors++; $display("FAIL disc_new_addr: got %h expected 0040", imem_addr); end
    out_ready = 1'b1;
    waited = 0;
    while (!out_valid && waited < 10) begin
      cycle();
      waited++;
    end
    checks++; if (out_pc !== 16'h0040 || out_valid !== 1'b1) begin errors++; $display("FAIL disc_first_out: got pc %h valid %b expected 0040 1", out_pc, out_valid); end
  endtask

  task automatic test_redirect_ack();
    int waited = 0;
    do_reset();
    while (queue_count !== 3'd1 && waited < 30) begin
      cycle();
      waited++;
    end
    checks++; if (queue_count !== 3'd1) begin errors++; $display("FAIL rack_fill: got %0d expected 1", queue_count); end
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h1234;
    cycle();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rack_idle: got %b expected 0", imem_req); end
    checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL rack_flush: got %0d expected 0", queue_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rack_no_stale: got %b expected 0", out_valid); end
    cycle();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rack_new_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 16'h1234) begin errors++; $display("FAIL rack_new_addr: got %h expected 1234", imem_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rack_still_empty: got %b expected 0", out_valid); end
    out_ready = 1'b1;
    waited = 0;
    while (!out_valid && waited < 10) begin
      cycle();
      waited++;
    end
    checks++; if (out_pc !== 16'h1234 || out_instr !== instr_of(16'h1234)) begin errors++; $display("FAIL rack_first_out: got pc %h instr %h expected 1234 %h", out_pc, out_instr, instr_of(16'h1234)); end
  endtask

  task automatic test_wrap();
    logic [15:0] wexp [4];
    int pops = 0;
    wexp[0] = 16'hFFFE;
    wexp[1] = 16'hFFFF;
    wexp[2] = 16'h0000;
    wexp[3] = 16'h0001;
    do_reset();
    out_ready_w = 1'b1;
    for (int i = 0; i < 30 && pops < 4; i++) begin
      if (out_valid_w) begin
        checks++; if (out_pc_w !== wexp[pops]) begin errors++; $display("FAIL wrap_pc: got %h expected %h", out_pc_w, wexp[pops]); end
        checks++; if (out_instr_w !== instr_of(wexp[pops])) begin errors++; $display("FAIL wrap_instr: got %h expected %h", out_instr_w, instr_of(wexp[pops])); end
        pops++;
      end
      cycle();
    end
    checks++; if (pops !== 4) begin errors++; $display("FAIL wrap_timeout: got %0d pops expected 4", pops); end
    out_ready_w = 1'b0;
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    do_reset();
    mem_lat   = 3;
    out_ready = 1'b1;
    while (!imem_req && waited < 5) begin
      cycle();
      waited++;
    end
    cycle();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rmid_in_request: got %b expected 1", imem_req); end
    Rst = 1'b1;
    cycle();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL rmid_addr: got %h expected 0000", imem_addr); end
    checks++; if (out_valid !== 1'b0 || out_pc !== 16'h0000 || out_instr !== 16'h0000) begin errors++; $display("FAIL rmid_outputs: got %b %h %h expected 0 0000 0000", out_valid, out_pc, out_instr); end
    checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", queue_count); end
    mem_auto   = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 16'hBEEF;
    Rst        = 1'b0;
    cycle();
    imem_ack = 1'b0;
    checks++; if (queue_count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL rmid_ack_ignored: got count %0d valid %b expected 0 0", queue_count, out_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL rmid_first_req: got %b %h expected 1 0000", imem_req, imem_addr); end
    mem_auto = 1'b1;
    mem_cnt  = 0;
    mem_lat  = 1;
    waited   = 0;
    while (!out_valid && waited < 10) begin
      cycle();
      waited++;
    end
    checks++; if (out_pc !== 16'h0000 || out_instr !== instr_of(16'h0000) || out_valid !== 1'b1) begin errors++; $display("FAIL rmid_first_out: got %b %h %h expected 1 0000 %h", out_valid, out_pc, out_instr, instr_of(16'h0000)); end
  endtask

  initial begin
    Rst              = 1'b1;
    redirect_valid   = 1'b0;
    redirect_pc      = 16'h0000;
    imem_ack         = 1'b0;
    imem_rdata       = 16'h0000;
    out_ready        = 1'b0;
    redirect_valid_w = 1'b0;
    redirect_pc_w    = 16'h0000;
    imem_ack_w       = 1'b0;
    imem_rdata_w     = 16'h0000;
    out_ready_w      = 1'b0;
    first_ack_addr   = 16'h0000;
    last_ack_addr    = 16'h0000;

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_discard();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
